truncador_saturado: RTL and testbench



---
 rtl/truncador_saturado_pkg.sv | 18 +
 rtl/truncador_saturado_contador_saturacion.sv | 50 +++++
 rtl/truncador_saturado.sv | 98 +++++++++
 tb/tb_truncador_saturado.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/truncador_saturado_pkg.sv
// Shared fixed-point defaults and saturation limits for the filter datapath.
package truncador_saturado_pkg;

  localparam int unsigned N_DEF = 24;  // sample width
  localparam int unsigned F_DEF = 8;   // fractional bits of a sample
  localparam int unsigned C_DEF = 16;  // saturation counter width

  // Largest positive value of an n-bit two's-complement word.
  function automatic longint sat_max(input int unsigned n);
    return (longint'(1) <<< (n - 1)) - longint'(1);
  endfunction

  // Most negative value of an n-bit two's-complement word.
  function automatic longint sat_min(input int unsigned n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/truncador_saturado_contador_saturacion.sv
// Sticky saturation flag plus C-bit saturating event counter.
// A clear coinciding with an event restarts the count at one.
module contador_saturacion
  import truncador_saturado_pkg::*;
#(
  parameter int unsigned C = C_DEF
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         evt_i,
  input  logic         clr_i,
  output logic         sat_flag_o,
  output logic [C-1:0] sat_count_o
);

  logic         flag_q, flag_d;
  logic [C-1:0] count_q, count_d;

  // Next flag/count: event beats clear, counter holds at all-ones.
  always_comb begin
    flag_d  = flag_q;
    count_d = count_q;
    if (evt_i) begin
      flag_d = 1'b1;
      if (clr_i) begin
        count_d = C'(1);
      end else if (count_q != {C{1'b1}}) begin
        count_d = count_q + C'(1);
      end
    end else if (clr_i) begin
      flag_d  = 1'b0;
      count_d = '0;
    end
  end

  // Telemetry registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flag_q  <= 1'b0;
      count_q <= '0;
    end else begin
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  assign sat_flag_o  = flag_q;
  assign sat_count_o = count_q;

endmodule

// File: rtl/truncador_saturado.sv
// Narrows a 2N-bit Q(2N-2F).(2F) value to an N-bit Q(N-F).F sample with
// saturation, through a 2-stage valid/ready pipeline.
// Build option TRUNC_ROUND_EN: round-half-up before the shift; otherwise
// plain truncation toward minus infinity.
module truncador_saturado
  import truncador_saturado_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned F = F_DEF,
  parameter int unsigned C = C_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [2*N-1:0] ValorExt,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   ValorSat,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           clr_sat,
  output logic           sat_flag,
  output logic [C-1:0]   sat_count
);

  localparam int unsigned W  = 2 * N + 1;
  localparam int unsigned RW = W - F;
  localparam logic [N-1:0] MAXV = N'(sat_max(N));
  localparam logic [N-1:0] MINV = N'(sat_min(N));
`ifdef TRUNC_ROUND_EN
  localparam logic signed [W-1:0] RND = W'(1) <<< (F - 1);
`endif

  logic signed [W-1:0]  ext_c, sum_c;
  logic [RW-1:0]        r_c;
  logic                 s_c;
  logic [N-1:0]         sample_c;
  logic                 advance_c;
  logic                 evt_c;

  logic                 v1_q, s1_q, v2_q, s2_q;
  logic [N-1:0]         r1_q, out_q;

  // Stage-1 arithmetic: extend, optional round, shift, clamp.
  always_comb begin
    ext_c = {ValorExt[2*N-1], ValorExt};
`ifdef TRUNC_ROUND_EN
    sum_c = ext_c + RND;
`else
    sum_c = ext_c;
`endif
    r_c      = RW'(sum_c >>> F);
    s_c      = !((&r_c[RW-1:N-1]) || !(|r_c[RW-1:N-1]));
    sample_c = r_c[N-1:0];
    if (s_c) begin
      sample_c = r_c[RW-1] ? MINV : MAXV;
    end
  end

  assign advance_c = !v2_q || out_ready;
  assign in_ready  = advance_c;

  // Two-stage pipeline; both stages move together on advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v1_q  <= 1'b0;
      r1_q  <= '0;
      s1_q  <= 1'b0;
      v2_q  <= 1'b0;
      out_q <= '0;
      s2_q  <= 1'b0;
    end else if (advance_c) begin
      v1_q <= in_valid;
      if (in_valid) begin
        r1_q <= sample_c;
        s1_q <= s_c;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        out_q <= r1_q;
        s2_q  <= s1_q;
      end
    end
  end

  assign ValorSat  = out_q;
  assign out_valid = v2_q;
  assign evt_c     = v2_q && out_ready && s2_q;

  contador_saturacion #(.C(C)) u_contador (
    .CLK         (CLK),
    .RESET       (RESET),
    .evt_i       (evt_c),
    .clr_i       (clr_sat),
    .sat_flag_o  (sat_flag),
    .sat_count_o (sat_count)
  );

endmodule

// File: tb/tb_truncador_saturado.sv
// Self-checking bench for truncador_saturado against an arithmetic model.
module tb_truncador_saturado;

  localparam int N = 24;
  localparam int F = 8;
  localparam int C = 16;
  localparam longint MAXL = (longint'(1) <<< (N - 1)) - 1;
  localparam longint MINL = -(longint'(1) <<< (N - 1));

  typedef struct {
    logic [N-1:0] val;
    bit           sat;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [2*N-1:0] ValorExt;
  logic           in_valid, in_ready;
  logic [N-1:0]   ValorSat;
  logic           out_valid, out_ready;
  logic           clr_sat;
  logic           sat_flag;
  logic [C-1:0]   sat_count;

  truncador_saturado #(.N(N), .F(F), .C(C)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ValorExt  (ValorExt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ValorSat  (ValorSat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_sat   (clr_sat),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 CLK = ~CLK;

  int      n_checks = 0;
  int      n_fail   = 0;
  exp_t    sb_q[$];
  bit      m_flag   = 1'b0;
  longint  m_count  = 0;
  bit      prev_stall = 1'b0;
  logic [N-1:0] prev_data;
  bit      last_in_x, last_out_x, last_in_ready;
  logic [N-1:0] last_out_val;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: real-valued rescale by 2^F, floor (or round-half-up), clamp.
  function automatic exp_t ref_model(input logic [2*N-1:0] x);
    exp_t   e;
    longint xv;
    longint q;
    xv = longint'($signed(x));
`ifdef TRUNC_ROUND_EN
    xv = xv + (longint'(1) <<< (F - 1));
`endif
    q = xv >>> F;
    e.sat = 1'b0;
    if (q > MAXL) begin q = MAXL; e.sat = 1'b1; end
    if (q < MINL) begin q = MINL; e.sat = 1'b1; end
    e.val = N'(q);
    return e;
  endfunction

  // One clock cycle: drive at negedge, sample before posedge, check telemetry after.
  task automatic step(input logic iv, input logic [2*N-1:0] v, input logic ordy, input logic clr);
    exp_t e;
    bit   sat_evt;
    @(negedge CLK);
    in_valid = iv; ValorExt = v; out_ready = ordy; clr_sat = clr;
    #1;
    last_in_x     = in_valid && in_ready;
    last_out_x    = out_valid && out_ready;
    last_in_ready = in_ready;
    sat_evt       = 1'b0;
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(ValorSat), 64'(prev_data));
    end
    if (last_out_x) begin
      last_out_val = ValorSat;
      if (sb_q.size() == 0) begin
        check("unexpected_out", 64'(last_out_x), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ValorSat", 64'(ValorSat), 64'(e.val));
        sat_evt = e.sat;
      end
    end
    if (last_in_x) sb_q.push_back(ref_model(v));
    prev_stall = out_valid && !out_ready;
    prev_data  = ValorSat;
    if (sat_evt) begin
      m_flag  = 1'b1;
      m_count = clr ? 1 : ((m_count == (longint'(1) <<< C) - 1) ? m_count : m_count + 1);
    end else if (clr) begin
      m_flag  = 1'b0;
      m_count = 0;
    end
    @(posedge CLK);
    #1;
    check("sat_flag", 64'(sat_flag), 64'(m_flag));
    check("sat_count", 64'(sat_count), 64'(m_count));
  endtask

  // Single sample with an idle pipeline; checks 2-cycle latency.
  task automatic run_single(input logic [2*N-1:0] v, input string tag, input logic [N-1:0] want);
    int lat;
    lat = -1;
    step(1'b1, v, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (last_out_x) begin lat = k; break; end
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check(tag, 64'(last_out_val), 64'(want));
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [2*N-1:0] svals [10];
  int idx, cyc;
  logic ordy;
  logic [2*N-1:0] rv;
  longint b;
  logic signed [31:0] t32;

  initial begin
    RESET = 1'b1; in_valid = 1'b0; ValorExt = '0; out_ready = 1'b1; clr_sat = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ValorSat", 64'(ValorSat), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);
    RESET = 1'b0;

    // Directed rounding/truncation cases.
`ifdef TRUNC_ROUND_EN
    run_single(48'h180, "pos_1p5", 24'd2);
    run_single(-48'sd384, "neg_1p5", 24'hFFFFFF);
`else
    run_single(48'h180, "pos_1p5", 24'd1);
    run_single(-48'sd384, "neg_1p5", 24'hFFFFFE);
`endif

    // Saturation in both directions.
    run_single(48'h0000_8000_0000, "sat_pos", 24'h7FFFFF);
    run_single(-(48'sd1 <<< 40), "sat_neg", 24'h800000);
    check("sat2_flag", 64'(sat_flag), 64'd1);
    check("sat2_count", 64'(sat_count), 64'd2);

    // Back-to-back stream with a 3-cycle downstream stall.
    for (int i = 0; i < 10; i++) svals[i] = 48'({$urandom, $urandom});
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 40) begin
      ordy = !(cyc >= 4 && cyc <= 6);
      step(1'b1, svals[idx], ordy, 1'b0);
      if (!ordy) check("stall_in_ready", 64'(last_in_ready), 64'd0);
      if (last_in_x) idx++;
      cyc++;
    end
    check("stream_sent", 64'(idx), 64'd10);
    drain();

    // Clear coinciding with a saturated output transfer.
    step(1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("clr_evt_flag", 64'(sat_flag), 64'd1);
    check("clr_evt_count", 64'(sat_count), 64'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("clr_only_flag", 64'(sat_flag), 64'd0);
    check("clr_only_count", 64'(sat_count), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: rv = 48'({$urandom, $urandom});
        1: begin t32 = $urandom; rv = 48'(t32); end
        default: begin
          b = $urandom_range(0, 1) ? MAXL : MINL;
          b = b * 256 + longint'($urandom_range(0, 1023)) - 512;
          rv = 48'(b);
        end
      endcase
      step($urandom_range(0, 3) != 0, rv, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    drain();

    // Reset with two samples in flight discards them.
    step(1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
    step(1'b1, 48'h8000_0000_0000, 1'b1, 1'b0);
    @(negedge CLK);
    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sat_count", 64'(sat_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);
    RESET = 1'b0;
    sb_q.delete();
    m_flag = 1'b0; m_count = 0; prev_stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("post_rst_no_out", 64'(last_out_x), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
